// File: rtl/crd_drop.sv
`default_nettype none
// ============================================================================
// Module  : crd_drop
// Purpose : Drops outer coordinates whose inner fiber is empty and folds the
//           stop tokens of those empty fibers into a single pending stop.
// Rev     : 1.0  initial release
// ============================================================================

module crd_drop (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        flush,
    input  logic        tile_en,
    input  logic [16:0] outer_crd_in,
    input  logic        outer_crd_in_valid,
    output logic        outer_crd_in_ready,
    input  logic [16:0] inner_crd_in,
    input  logic        inner_crd_in_valid,
    output logic        inner_crd_in_ready,
    output logic [16:0] outer_crd_out,
    output logic        outer_crd_out_valid,
    input  logic        outer_crd_out_ready,
    output logic [16:0] inner_crd_out,
    output logic        inner_crd_out_valid,
    input  logic        inner_crd_out_ready
);

    typedef enum logic [2:0] {
        S_OUTER = 3'd0,
        S_FIBER = 3'd1,
        S_BODY  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic        pend_valid_q, pend_valid_d;
    logic [7:0]  pend_lvl_q, pend_lvl_d;
    // Per-output "already delivered" flags for the paired FIBER emission.
    logic        osent_q, osent_d, isent_q, isent_d;

    logic        w_clr, w_act;
    logic        w_o_data, w_o_done, w_i_data, w_i_stop, w_i_done;
    logic [16:0] w_pend_tok;
    logic        w_oin_fire, w_iin_fire, w_oout_fire, w_iout_fire;

    assign w_clr      = rst | flush;
    assign w_act      = tile_en & ~w_clr;
    assign w_o_data   = ~outer_crd_in[16];
    assign w_o_done   = outer_crd_in[16] & outer_crd_in[8];
    assign w_i_data   = ~inner_crd_in[16];
    assign w_i_done   = inner_crd_in[16] & inner_crd_in[8];
    assign w_i_stop   = inner_crd_in[16] & ~inner_crd_in[8];
    assign w_pend_tok = {9'h100, pend_lvl_q};

    always_comb begin : p_out
        outer_crd_in_ready  = 1'b0;
        inner_crd_in_ready  = 1'b0;
        outer_crd_out       = '0;
        outer_crd_out_valid = 1'b0;
        inner_crd_out       = '0;
        inner_crd_out_valid = 1'b0;
        case (state_q)
            S_OUTER: begin
                if (w_o_data) begin
                    outer_crd_in_ready = 1'b1;
                end else begin
                    outer_crd_out       = outer_crd_in;
                    outer_crd_out_valid = outer_crd_in_valid;
                    outer_crd_in_ready  = outer_crd_out_ready;
                end
            end
            S_FIBER: begin
                if (w_i_data) begin
                    if (pend_valid_q) begin
                        inner_crd_out       = w_pend_tok;
                        inner_crd_out_valid = inner_crd_in_valid;
                    end else begin
                        outer_crd_out       = {1'b0, hold_q};
                        outer_crd_out_valid = inner_crd_in_valid & ~osent_q;
                        inner_crd_out       = inner_crd_in;
                        inner_crd_out_valid = inner_crd_in_valid & ~isent_q;
                        inner_crd_in_ready  = (outer_crd_out_ready | osent_q) &
                                              (inner_crd_out_ready | isent_q);
                    end
                end else if (w_i_stop) begin
                    if (pend_valid_q || inner_crd_in[7:0] == 8'd0) begin
                        inner_crd_in_ready = 1'b1;
                    end else begin
                        inner_crd_out       = inner_crd_in;
                        inner_crd_out_valid = inner_crd_in_valid;
                        inner_crd_in_ready  = inner_crd_out_ready;
                    end
                end
            end
            S_BODY: begin
                if (w_i_data) begin
                    inner_crd_out       = inner_crd_in;
                    inner_crd_out_valid = inner_crd_in_valid;
                    inner_crd_in_ready  = inner_crd_out_ready;
                end else if (w_i_stop) begin
                    inner_crd_in_ready = 1'b1;
                end
            end
            S_DRAIN: begin
                if (w_i_done) begin
                    if (pend_valid_q) begin
                        inner_crd_out       = w_pend_tok;
                        inner_crd_out_valid = inner_crd_in_valid;
                    end else begin
                        inner_crd_out       = inner_crd_in;
                        inner_crd_out_valid = inner_crd_in_valid;
                        inner_crd_in_ready  = inner_crd_out_ready;
                    end
                end
            end
            default: ;
        endcase
        if (!w_act) begin
            outer_crd_in_ready  = 1'b0;
            inner_crd_in_ready  = 1'b0;
            outer_crd_out_valid = 1'b0;
            inner_crd_out_valid = 1'b0;
        end
        if (w_clr) begin
            outer_crd_out = '0;
            inner_crd_out = '0;
        end
    end

    assign w_oin_fire  = outer_crd_in_valid  & outer_crd_in_ready  & clk_en;
    assign w_iin_fire  = inner_crd_in_valid  & inner_crd_in_ready  & clk_en;
    assign w_oout_fire = outer_crd_out_valid & outer_crd_out_ready & clk_en;
    assign w_iout_fire = inner_crd_out_valid & inner_crd_out_ready & clk_en;

    always_comb begin : p_next
        state_d      = state_q;
        hold_d       = hold_q;
        pend_valid_d = pend_valid_q;
        pend_lvl_d   = pend_lvl_q;
        osent_d      = osent_q;
        isent_d      = isent_q;
        case (state_q)
            S_OUTER: begin
                if (w_oin_fire) begin
                    if (w_o_data) begin
                        hold_d  = outer_crd_in[15:0];
                        state_d = S_FIBER;
                    end else if (w_o_done) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_FIBER: begin
                if (w_i_data && pend_valid_q) begin
                    if (w_iout_fire) begin
                        pend_valid_d = 1'b0;
                        pend_lvl_d   = '0;
                    end
                end else if (w_i_data) begin
                    osent_d = osent_q | w_oout_fire;
                    isent_d = isent_q | w_iout_fire;
                    if (w_iin_fire) begin
                        osent_d = 1'b0;
                        isent_d = 1'b0;
                        state_d = S_BODY;
                    end
                end else if (w_iin_fire) begin
                    hold_d  = '0;
                    state_d = S_OUTER;
                    if (pend_valid_q && inner_crd_in[7:0] > pend_lvl_q)
                        pend_lvl_d = inner_crd_in[7:0];
                end
            end
            S_BODY: begin
                if (w_iin_fire && w_i_stop) begin
                    pend_valid_d = 1'b1;
                    pend_lvl_d   = inner_crd_in[7:0];
                    state_d      = S_OUTER;
                end
            end
            S_DRAIN: begin
                if (w_iout_fire) begin
                    if (pend_valid_q) begin
                        pend_valid_d = 1'b0;
                        pend_lvl_d   = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (clk_en)
                    state_d = S_OUTER;
            end
            default: state_d = S_OUTER;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q      <= S_OUTER;
            hold_q       <= '0;
            pend_valid_q <= 1'b0;
            pend_lvl_q   <= '0;
            osent_q      <= 1'b0;
            isent_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            pend_valid_q <= pend_valid_d;
            pend_lvl_q   <= pend_lvl_d;
            osent_q      <= osent_d;
            isent_q      <= isent_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_crd_drop.sv
`default_nettype none
// ============================================================================
// Module  : tb_crd_drop
// Purpose : Scoreboard bench for crd_drop token filtering and handshakes.
// Rev     : 1.0  initial release
// ============================================================================

module tb_crd_drop;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_en = 1'b1;
    logic        flush = 1'b0;
    logic        tile_en = 1'b1;
    logic [16:0] outer_crd_in = '0;
    logic        outer_crd_in_valid = 1'b0;
    logic        outer_crd_in_ready;
    logic [16:0] inner_crd_in = '0;
    logic        inner_crd_in_valid = 1'b0;
    logic        inner_crd_in_ready;
    logic [16:0] outer_crd_out;
    logic        outer_crd_out_valid;
    logic        outer_crd_out_ready = 1'b1;
    logic [16:0] inner_crd_out;
    logic        inner_crd_out_valid;
    logic        inner_crd_out_ready = 1'b1;

    crd_drop u_dut (
        .clk                 (clk),
        .rst                 (rst),
        .clk_en              (clk_en),
        .flush               (flush),
        .tile_en             (tile_en),
        .outer_crd_in        (outer_crd_in),
        .outer_crd_in_valid  (outer_crd_in_valid),
        .outer_crd_in_ready  (outer_crd_in_ready),
        .inner_crd_in        (inner_crd_in),
        .inner_crd_in_valid  (inner_crd_in_valid),
        .inner_crd_in_ready  (inner_crd_in_ready),
        .outer_crd_out       (outer_crd_out),
        .outer_crd_out_valid (outer_crd_out_valid),
        .outer_crd_out_ready (outer_crd_out_ready),
        .inner_crd_out       (inner_crd_out),
        .inner_crd_out_valid (inner_crd_out_valid),
        .inner_crd_out_ready (inner_crd_out_ready)
    );

    always #5 clk = ~clk;

    logic [16:0] src_o[$];
    logic [16:0] src_i[$];
    logic [16:0] exp_o[$];
    logic [16:0] exp_i[$];
    int          n_err = 0;
    int          n_chk = 0;
    int          cyc;
    int          o_cnt;
    int          i_cnt;
    logic        bp;
    logic        gap;
    logic        pv_o, pv_i;
    logic [16:0] pd_o, pd_i;
    logic        done_seen;

    task automatic check(input string tag, input logic [39:0] act, input logic [39:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] hs();
        return {outer_crd_in_ready, inner_crd_in_ready, outer_crd_out_valid, inner_crd_out_valid};
    endfunction

    task automatic load_inputs();
        outer_crd_in_valid = (src_o.size() > 0);
        outer_crd_in       = (src_o.size() > 0) ? src_o[0] : 17'd0;
        inner_crd_in_valid = (src_i.size() > 0);
        inner_crd_in       = (src_i.size() > 0) ? src_i[0] : 17'd0;
    endtask

    // One clock: sample/score at negedge, advance sources just after posedge.
    task automatic step();
        logic fo_in, fi_in, fo_out, fi_out;
        @(negedge clk);
        fo_in  = outer_crd_in_valid  & outer_crd_in_ready  & clk_en & tile_en;
        fi_in  = inner_crd_in_valid  & inner_crd_in_ready  & clk_en & tile_en;
        fo_out = outer_crd_out_valid & outer_crd_out_ready & clk_en & tile_en;
        fi_out = inner_crd_out_valid & inner_crd_out_ready & clk_en & tile_en;
        if (pv_o) check("o_stable", {outer_crd_out_valid, outer_crd_out}, {1'b1, pd_o});
        if (pv_i) check("i_stable", {inner_crd_out_valid, inner_crd_out}, {1'b1, pd_i});
        if (done_seen) check("done_idle", {36'd0, hs()}, 40'd0);
        if (fo_out) begin
            o_cnt++;
            if (exp_o.size() > 0) check("o_tok", {23'd0, outer_crd_out}, {23'd0, exp_o.pop_front()});
        end
        if (fi_out) begin
            i_cnt++;
            if (exp_i.size() > 0) check("i_tok", {23'd0, inner_crd_out}, {23'd0, exp_i.pop_front()});
        end
        pv_o      = outer_crd_out_valid & ~fo_out;
        pd_o      = outer_crd_out;
        pv_i      = inner_crd_out_valid & ~fi_out;
        pd_i      = inner_crd_out;
        done_seen = fi_out && (inner_crd_out == 17'h10100);
        @(posedge clk);
        #1;
        if (fo_in) void'(src_o.pop_front());
        if (fi_in) void'(src_i.pop_front());
        load_inputs();
        cyc++;
        clk_en              = !(gap && cyc >= 6 && cyc < 9);
        outer_crd_out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        inner_crd_out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic run(input logic b, input logic g);
        int no, ni;
        no = exp_o.size();
        ni = exp_i.size();
        bp = b; gap = g; cyc = 0; o_cnt = 0; i_cnt = 0;
        pv_o = 1'b0; pv_i = 1'b0; done_seen = 1'b0;
        load_inputs();
        for (int k = 0; k < 400 && (exp_o.size() > 0 || exp_i.size() > 0); k++) step();
        for (int k = 0; k < 3; k++) step();
        check("o_count", 40'(o_cnt), 40'(no));
        check("i_count", 40'(i_cnt), 40'(ni));
        check("src_left", 40'(src_o.size() + src_i.size()), 40'd0);
        clk_en = 1'b1; outer_crd_out_ready = 1'b1; inner_crd_out_ready = 1'b1;
    endtask

    task automatic load_basic();
        src_o = '{17'd5, 17'd7, 17'd9, 17'h10000, 17'h10100};
        src_i = '{17'd1, 17'd2, 17'h10000, 17'h10000, 17'd3, 17'h10001, 17'h10100};
        exp_o = '{17'd5, 17'd9, 17'h10000, 17'h10100};
        exp_i = '{17'd1, 17'd2, 17'h10000, 17'd3, 17'h10001, 17'h10100};
    endtask

    initial begin
        bp = 1'b0; gap = 1'b0; pv_o = 1'b0; pv_i = 1'b0; done_seen = 1'b0;
        cyc = 0; o_cnt = 0; i_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        check("rst_out", {2'd0, hs(), outer_crd_out, inner_crd_out}, 40'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        load_basic();
        run(1'b0, 1'b0);

        src_o = '{17'd4, 17'd6, 17'h10000, 17'h10100};
        src_i = '{17'd1, 17'h10000, 17'h10001, 17'h10100};
        exp_o = '{17'd4, 17'h10000, 17'h10100};
        exp_i = '{17'd1, 17'h10001, 17'h10100};
        run(1'b0, 1'b0);

        src_o = '{17'd2, 17'd3, 17'h10000, 17'h10100};
        src_i = '{17'h10000, 17'h10001, 17'h10100};
        exp_o = '{17'h10000, 17'h10100};
        exp_i = '{17'h10001, 17'h10100};
        run(1'b0, 1'b0);

        load_basic();
        run(1'b1, 1'b1);

        // Park the block in FIBER holding 7, then reset it away.
        src_o = '{17'd7};
        bp = 1'b0; gap = 1'b0;
        load_inputs();
        for (int k = 0; k < 20 && src_o.size() > 0; k++) step();
        check("fiber_taken", 40'(src_o.size()), 40'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid", {2'd0, hs(), outer_crd_out, inner_crd_out}, 40'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        load_basic();
        run(1'b0, 1'b0);

        tile_en = 1'b0;
        outer_crd_in = 17'd3;  outer_crd_in_valid = 1'b1;
        inner_crd_in = 17'd1;  inner_crd_in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("tile_off", {36'd0, hs()}, 40'd0);
        end
        outer_crd_in_valid = 1'b0;
        inner_crd_in_valid = 1'b0;
        tile_en = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
